// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback datapath: load lane extraction, register
// file write port and forwarding tap. Optional retire counter via `WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_regwrite,
  input  logic                  in_mem_to_reg,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_signed,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  wena,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           retire_count
`endif
);

  logic                  valid_reg;
  logic                  regwrite_reg;
  logic                  mem_to_reg_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [DATA_WIDTH-1:0] alu_reg;
  logic [DATA_WIDTH-1:0] mem_rdata_reg;
  logic [1:0]            ld_size_reg;
  logic                  ld_signed_reg;
  logic                  written_reg;

  logic                  eligible;
  logic [1:0]            off;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      regwrite_reg   <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      waddr_reg      <= '0;
      alu_reg        <= '0;
      mem_rdata_reg  <= '0;
      ld_size_reg    <= 2'b00;
      ld_signed_reg  <= 1'b0;
      written_reg    <= 1'b0;
    end else if (stall && !flush) begin
      // Held entry: remember that its single register file write already happened.
      if (wena) written_reg <= 1'b1;
    end else begin
      valid_reg      <= in_valid && !flush;
      regwrite_reg   <= in_regwrite;
      mem_to_reg_reg <= in_mem_to_reg;
      waddr_reg      <= in_waddr;
      alu_reg        <= in_alu_result;
      mem_rdata_reg  <= in_mem_rdata;
      ld_size_reg    <= in_ld_size;
      ld_signed_reg  <= in_ld_signed;
      written_reg    <= 1'b0;
    end
  end

  // Little-endian lanes; half loads ignore off[0], word loads ignore the offset.
  always_comb begin
    off       = alu_reg[1:0];
    byte_lane = mem_rdata_reg[{off, 3'b000} +: 8];
    half_lane = mem_rdata_reg[{off[1], 4'b0000} +: 16];
    case (ld_size_reg)
      2'b00:   load_data = {{(DATA_WIDTH-8){ld_signed_reg & byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{(DATA_WIDTH-16){ld_signed_reg & half_lane[15]}}, half_lane};
      default: load_data = mem_rdata_reg;
    endcase
    result = mem_to_reg_reg ? load_data : alu_reg;
  end

  assign eligible  = valid_reg && regwrite_reg &&
                     !((ZERO_REG != 0) && (waddr_reg == '0));
  assign wena      = eligible && !written_reg;
  assign waddr     = waddr_reg;
  assign wdata     = result;
  assign fwd_valid = eligible;
  assign fwd_addr  = waddr_reg;
  assign fwd_data  = result;

`ifdef WB_RETIRE_CNT_EN
  // An instruction retires on the edge where it leaves the stage (not held, or killed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (valid_reg && (!stall || flush)) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver queues the expected write port state
// for the following cycle, a negedge monitor pops and compares.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_regwrite = 1'b0, in_mem_to_reg = 1'b0;
  logic [4:0]  in_waddr = '0;
  logic [31:0] in_alu_result = '0, in_mem_rdata = '0;
  logic [1:0]  in_ld_size = 2'b00;
  logic        in_ld_signed = 1'b0, stall = 1'b0, flush = 1'b0;

  logic        wena, fwd_valid, wena0, fwd_valid0;
  logic [4:0]  waddr, fwd_addr, waddr0, fwd_addr0;
  logic [31:0] wdata, fwd_data, wdata0, fwd_data0;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] rc, rc0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        we, fv, we0, chk;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;
  exp_t sb[$];

  logic [31:0] byte_s[4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
  logic [31:0] byte_u[4] = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};

  wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_regwrite(in_regwrite),
    .in_mem_to_reg(in_mem_to_reg), .in_waddr(in_waddr), .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .stall(stall), .flush(flush), .wena(wena), .waddr(waddr), .wdata(wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(rc)
`endif
  );

  wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_regwrite(in_regwrite),
    .in_mem_to_reg(in_mem_to_reg), .in_waddr(in_waddr), .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .stall(stall), .flush(flush), .wena(wena0), .waddr(waddr0), .wdata(wdata0),
    .fwd_valid(fwd_valid0), .fwd_addr(fwd_addr0), .fwd_data(fwd_data0)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(rc0)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation that falls due in this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (e.cyc != cyc || wena !== e.we || fwd_valid !== e.fv || wena0 !== e.we0 ||
            (e.chk && (waddr !== e.wa || wdata !== e.wd || fwd_addr !== e.wa || fwd_data !== e.wd))) begin
          n_bad++;
          $display("FAIL wb cyc=%0d (due %0d): got wena=%b fv=%b wena0=%b waddr=%0d wdata=%h fwd=%0d/%h, want wena=%b fv=%b wena0=%b waddr=%0d wdata=%h",
                   cyc, e.cyc, wena, fwd_valid, wena0, waddr, wdata, fwd_addr, fwd_data,
                   e.we, e.fv, e.we0, e.wa, e.wd);
        end else begin
          $display("ok   wb cyc=%0d wena=%b fv=%b waddr=%0d wdata=%h", cyc, wena, fwd_valid, waddr, wdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, rw, m2r, input logic [4:0] wa, input logic [31:0] alu, rd,
                     input logic [1:0] sz, input logic sg, st, fl);
    in_valid = v; in_regwrite = rw; in_mem_to_reg = m2r; in_waddr = wa;
    in_alu_result = alu; in_mem_rdata = rd; in_ld_size = sz; in_ld_signed = sg;
    stall = st; flush = fl;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_next(input logic we, fv, we0, chk, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    e.cyc = cyc + 1; e.we = we; e.fv = fv; e.we0 = we0; e.chk = chk; e.wa = wa; e.wd = wd;
    sb.push_back(e);
  endtask

  initial begin
    // Reset held with a valid write on the inputs: everything must stay 0.
    drv(1'b1, 1'b1, 1'b0, 5'd3, 32'h12345678, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({wena, fwd_valid, waddr, wdata, wena0, fwd_valid0} !== '0) begin
      n_bad++;
      $display("FAIL reset: got wena=%b fv=%b waddr=%0d wdata=%h wena0=%b, want all 0",
               wena, fwd_valid, waddr, wdata, wena0);
    end else $display("ok   reset outputs 0");
    idle();
    #2 rst_n = 1'b1;
    tick();

    // ALU writeback
    drv(1'b1, 1'b1, 1'b0, 5'd3, 32'h12345678, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd3, 32'h12345678);
    // Byte loads, signed then unsigned
    for (int i = 0; i < 4; i++) begin
      tick();
      drv(1'b1, 1'b1, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h80FF7F01, 2'b00, 1'b1, 1'b0, 1'b0);
      expect_next(1, 1, 1, 1, 5'(i + 1), byte_s[i]);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      drv(1'b1, 1'b1, 1'b1, 5'd6, 32'h200 + 32'(i), 32'h80FF7F01, 2'b00, 1'b0, 1'b0, 1'b0);
      expect_next(1, 1, 1, 1, 5'd6, byte_u[i]);
    end
    // Half loads
    tick(); drv(1'b1, 1'b1, 1'b1, 5'd7, 32'h2, 32'h8001FFFE, 2'b01, 1'b1, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd7, 32'hFFFF8001);
    tick(); drv(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 32'h8001FFFE, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd7, 32'h0000FFFE);
    tick(); drv(1'b1, 1'b1, 1'b1, 5'd7, 32'h3, 32'h8001FFFE, 2'b01, 1'b1, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd7, 32'hFFFF8001);
    // Word loads, size 10 and 11, offset ignored
    tick(); drv(1'b1, 1'b1, 1'b1, 5'd9, 32'h3, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd9, 32'hDEADBEEF);
    tick(); drv(1'b1, 1'b1, 1'b1, 5'd9, 32'h1, 32'hCAFEF00D, 2'b11, 1'b1, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd9, 32'hCAFEF00D);
    // Register 0: suppressed only when ZERO_REG=1
    tick(); drv(1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_next(0, 0, 1, 1, 5'd0, 32'h55);
    // Valid but not writing
    tick(); drv(1'b1, 1'b0, 1'b0, 5'd4, 32'h44, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_next(0, 0, 0, 1, 5'd4, 32'h44);

    // Stall held for three cycles on r5=0xA5: one write, forwarding throughout
    tick(); drv(1'b1, 1'b1, 1'b0, 5'd5, 32'hA5, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd5, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick(); drv(1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0);
      expect_next(0, 1, 0, 1, 5'd5, 32'hA5);
    end
    tick(); drv(1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd6, 32'h66);

    // Flush beats stall on a valid held entry
    tick(); drv(1'b1, 1'b1, 1'b0, 5'd8, 32'h88, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd8, 32'h88);
    tick(); drv(1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1);
    expect_next(0, 0, 0, 0, 5'd0, 32'h0);
    // Plain flush kills the incoming instruction; the next one proceeds
    tick(); drv(1'b1, 1'b1, 1'b0, 5'd10, 32'hAA, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1);
    expect_next(0, 0, 0, 0, 5'd0, 32'h0);
    tick(); drv(1'b1, 1'b1, 1'b0, 5'd11, 32'hBB, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    expect_next(1, 1, 1, 1, 5'd11, 32'hBB);
    tick(); idle();
    expect_next(0, 0, 0, 1, 5'd0, 32'h0);
    tick(); tick(); tick();

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d entries left, want 0", sb.size());
    end else $display("ok   scoreboard drained");

`ifdef WB_RETIRE_CNT_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); drv(1'b1, 1'b0, 1'b0, 5'(i + 12), 32'(i), 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    end
    tick(); idle();
    tick(); tick();
    n_cmp++;
    if (rc !== 32'd4) begin
      n_bad++;
      $display("FAIL retire_count: got %0d, want 4", rc);
    end else $display("ok   retire_count=%0d", rc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
